serial_parity_frame_rx: RTL
===========================

// Module: serial_parity_frame_rx
// PURPOSE
//  Receives one asynchronous serial frame on rx: start, 8 data bits sent LSB first,
//  one parity bit and one stop bit. Emits the data byte and the received parity bit
//  through a valid/ready holding register.
//  Sits directly upstream of the parity checker: out_data drives its data input and
//  out_parity drives its parity_bit input. Parity is not judged here.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 4..1023; even values only
// PORTS
//  clk          in   1  single system clock; all logic uses the rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  rx           in   1  serial line; idle high; asynchronous to clk
//  out_data     out  8  received byte; bit0 is the first data bit on the line
//  out_parity   out  1  received parity bit
//  out_valid    out  1  out_data, out_parity and frame_err are held and valid
//  out_ready    in   1  consumer accepts the held frame when out_valid=1
//  frame_err    out  1  stop bit was sampled as 0; qualified by out_valid
//  overrun      out  1  one-cycle pulse: a completed frame was dropped
//  busy         out  1  FSM is in any state other than IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, out_data=0, out_parity=0, out_valid=0, frame_err=0, overrun=0,
//    busy=0. The synchronizer flops reset to 1. Counters reset to 0.
//  - rx passes through a 2-flop synchronizer; rx_s is the output of the 2nd flop.
//    All FSM decisions use rx_s.
//  - Bit timer (baud_cnt) counts from 0 to CLKS_PER_BIT-1, then returns to 0.
//  - IDLE: when rx_s=0, go to START and clear baud_cnt.
//  - START: at baud_cnt=CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
//      - rx_s=1 means a glitch: go back to IDLE; no output; no flag.
//      - rx_s=0: go to DATA; clear baud_cnt and bit_idx.
//  - DATA: at each baud_cnt=CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx].
//    After bit_idx=7, go to PARITY.
//  - PARITY: at baud_cnt=CLKS_PER_BIT-1, capture rx_s into par_r and go to STOP.
//  - STOP: at baud_cnt=CLKS_PER_BIT-1, sample the stop bit.
//    Call this cycle "complete". The FSM goes to IDLE on the next edge.
//  - On complete, the frame is loaded into the holding register when either:
//      - out_valid=0, or
//      - out_valid=1 and out_ready=1 in the same cycle (old frame is consumed and the
//        new frame is loaded; no overrun).
//    Loaded values: out_data=shreg, out_parity=par_r, frame_err=~rx_s, out_valid=1.
//    These are visible on the cycle after complete.
//  - Overrun: complete while out_valid=1 and out_ready=0.
//      - The new frame is discarded; the held frame is unchanged.
//      - overrun=1 for exactly the next cycle.
//  - A frame with a stop-bit error is still delivered, with frame_err=1. It is never
//    dropped silently.
//  - Handshake: the held frame is consumed on a cycle with out_valid=1 and out_ready=1.
//    out_valid drops on the next cycle unless a new frame loads in that same cycle.
//    Held outputs stay stable while out_valid=1 and out_ready=0.
//  - out_ready is ignored when out_valid=0.
//  - Back-to-back frames: IDLE detects a new start in the first cycle after STOP.
//    Minimum inter-frame gap is 0 extra bits.
//  - Latency: the first rx falling edge to out_valid=1 is
//    2 (sync) + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles.
//  - Reset asserted mid-frame aborts immediately: all state and outputs return to
//    reset values. After release, the FSM waits in IDLE for rx_s=0.
//    A partially received frame is never emitted.
// TESTING (CLKS_PER_BIT=16)
//  1. Send 0xA5 with parity=0 and stop=1, out_ready held 1 -> out_valid high for
//     1 cycle with out_data=0xA5, out_parity=0, frame_err=0; latency = 171 cycles.
//  2. Send 0x3C with parity=1 and stop=0 -> out_data=0x3C, out_parity=1, frame_err=1,
//     out_valid=1.
//  3. rx low for 5 cycles, then high -> FSM returns to IDLE; out_valid stays 0;
//     busy returns to 0.
//  4. out_ready=0; send 0x11, then 0x22 back-to-back -> out_data stays 0x11;
//     overrun pulses 1 cycle at the 2nd complete; raising out_ready then delivers 0x11.
//  5. Hold 0x11, then assert out_ready exactly at the complete cycle of 0x22 ->
//     0x11 is consumed, 0x22 is loaded, out_valid stays 1, overrun=0.
//  6. Assert rst_n=0 during data bit 4 of 0xFF, release, then send 0x81 ->
//     only 0x81 is emitted; all outputs were 0 during reset.

Source files
------------

// File: rtl/serial_parity_frame_rx.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop.
// Delivers data and the raw parity bit through a valid/ready holding register.
module serial_parity_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_parity,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            complete;

  logic [7:0]      out_data_q, out_data_d;
  logic            out_parity_q, out_parity_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            load;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CntW'(1);
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    complete   = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_cnt_q == CntHalf) begin
          baud_cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (baud_cnt_q == CntFull) begin
          baud_cnt_d         = '0;
          shreg_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (baud_cnt_q == CntFull) begin
          baud_cnt_d = '0;
          par_d      = rx_s_q;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (baud_cnt_q == CntFull) begin
          baud_cnt_d = '0;
          complete   = 1'b1;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        baud_cnt_d = '0;
      end
    endcase
  end

  // A consume and a new load in the same cycle replace the frame without overrun.
  always_comb begin
    load         = complete && (!out_valid_q || out_ready);
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    frame_err_d  = frame_err_q;
    out_valid_d  = out_valid_q;
    overrun_d    = complete && out_valid_q && !out_ready;
    if (load) begin
      out_data_d   = shreg_q;
      out_parity_d = par_q;
      frame_err_d  = ~rx_s_q;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule
